// File: rtl/bus_pkg.sv
// Shared bus-side definitions: owner FSM encoding, TURN counter width and
// the oe_n decode that both the arbiter and bus monitors rely on.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } bus_state_e;

    localparam int TURN_CNT_W = 3;

    // Only DRIVE ever enables a buffer, and only the owner's.
    function automatic logic [1:0] oe_decode(input bus_state_e st, input logic owner);
        logic [1:0] oe_n;
        case (st)
            ST_DRIVE: oe_n = owner ? 2'b01 : 2'b10;
            default:  oe_n = 2'b11;
        endcase
        return oe_n;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-source combinational arbiter: a lone requester wins, a tie goes to the
// source that did not own the bus last.
module rr_pick2 (
    input  logic [1:0] req_valid_i,
    input  logic       last_owner_i,
    output logic [1:0] grant_o
);

    // One-hot grant selection.
    always_comb begin
        grant_o = 2'b00;
        case (req_valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_owner_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/bus_owner_arbiter.sv
// Shared-bus owner arbiter: grants one of two sources, registers its word
// onto drv_data and enforces TURNAROUND idle cycles between different owners.
module bus_owner_arbiter
    import bus_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TURNAROUND = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    output logic [1:0]       req_ready,
    output logic [WIDTH-1:0] drv_data,
    output logic [1:0]       oe_n,
    output logic             bus_busy
);

    bus_state_e            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic [TURN_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            oe_n_q;
    logic                  busy_q;
    logic [1:0]            grant_s;
    logic [1:0]            ready_s;
    logic [1:0]            accept_s;
    logic                  accept_src_s;

    rr_pick2 u_pick (
        .req_valid_i  (req_valid),
        .last_owner_i (last_owner_q),
        .grant_o      (grant_s)
    );

    assign req_ready    = rst_n ? ready_s : 2'b00;
    assign accept_s     = req_valid & req_ready;
    assign accept_src_s = accept_s[1];

    // Next-state, ready generation and data capture.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        ready_s      = 2'b00;
        case (state_q)
            ST_IDLE: begin
                ready_s = grant_s;
                if (accept_s != 2'b00) begin
                    state_d      = ST_DRIVE;
                    owner_d      = accept_src_s;
                    last_owner_d = accept_src_s;
                    data_d       = accept_src_s ? req_data1 : req_data0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                // The owner may stream only while the other source is silent.
                if (req_valid[owner_q] && !req_valid[~owner_q]) begin
                    ready_s = owner_q ? 2'b10 : 2'b01;
                end else begin
                    ready_s = 2'b00;
                end
                if (accept_s != 2'b00) begin
                    data_d = owner_q ? req_data1 : req_data0;
                end else begin
                    state_d = ST_TURN;
                    cnt_d   = TURN_CNT_W'(TURNAROUND - 1);
                end
            end
            ST_TURN: begin
                if (cnt_q == {TURN_CNT_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - {{(TURN_CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, data and registered bus-control outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            data_q       <= {WIDTH{1'b0}};
            cnt_q        <= {TURN_CNT_W{1'b0}};
            oe_n_q       <= 2'b11;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            oe_n_q       <= oe_decode(state_d, owner_d);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign drv_data = data_q;
    assign oe_n     = oe_n_q;
    assign bus_busy = busy_q;

endmodule
